// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO that feeds uart_tx one byte at a time
// over a toggle req/ack handshake, holding tx_data stable while pending.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic                  busy,
  output logic                  req,
  output logic [7:0]            tx_data,
  input  logic                  ack
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t                r_state, w_state_nxt;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count, w_count_nxt;
  logic                  r_full, r_empty, r_ovf, r_req;
  logic [7:0]            r_tx_data;
  logic                  w_wr, w_pop;
  // flush blocks a launch in the same cycle so no byte escapes a clear
  always_comb begin
    w_pop = 1'b0;
    w_state_nxt = r_state;
    if (r_state == IDLE) begin
      w_pop = enable && !r_empty && (r_req == ack) && !flush;
      w_state_nxt = w_pop ? WAIT : IDLE;
    end else begin
      w_state_nxt = (r_req == ack) ? IDLE : WAIT;
    end
  end
  assign w_wr = wr_en && !r_full && !flush;
  assign w_count_nxt = flush ? '0 :
    r_count + {{DEPTH_LOG2{1'b0}}, w_wr} - {{DEPTH_LOG2{1'b0}}, w_pop};
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end
  // count only reaches DEPTH when full, so its MSB is the full flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_ovf     <= 1'b0;
      r_req     <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= w_count_nxt[DEPTH_LOG2];
      r_empty <= (w_count_nxt == '0);
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_pop) begin
        r_tx_data <= r_mem[r_rd_ptr];
        r_req     <= ~r_req;
      end
      if (wr_en && r_full && !flush) r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end
  assign full     = r_full;
  assign empty    = r_empty;
  assign count    = r_count;
  assign overflow = r_ovf;
  assign busy     = (r_state == WAIT);
  assign req      = r_req;
  assign tx_data  = r_tx_data;
endmodule
